// File: rtl/seg_pkg.sv
// Shared constants for the seven-segment display path.
// Latency: n/a (constants only).
// Backpressure: n/a.
package seg_pkg;

    // All segments off (active-low bank)
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Bit positions inside the 7-bit segment vector {g,f,e,d,c,b,a}
    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    // Hex-to-segment table, active-low; entry n sits at index n (0 at the LSB end)
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

endpackage

// File: rtl/seg_display_ctrl_hex7seg_decode.sv
// Hex nibble to active-low seven-segment pattern.
// Latency: combinational.
// Backpressure: none.
module hex7seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg
);

    assign o_seg = HEX_SEG[i_hex];

endmodule

// File: rtl/seg_display_ctrl.sv
// Multiplexed common-anode seven-segment driver with enable/blink/dp masks and LZ suppression.
// Latency: outputs registered one cycle after the scan state; loaded values visible the cycle after load.
// Backpressure: none; load is a one-cycle strobe that is always accepted outside reset.
module seg_display_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 6250,
    parameter int BLANK_CYC   = 25,
    parameter int BLINK_DIV   = 100,
    parameter int LED_W       = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic [NUM_DIGITS-1:0]   blink_msk,
    input  logic [NUM_DIGITS-1:0]   dp_msk,
    input  logic                    lz_en,
    input  logic                    set,
    input  logic [LED_W-3:0]        led_in,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    dp,
    output logic [LED_W-1:0]        led
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam int FW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] BLANK_END  = PW'(BLANK_CYC);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_DIV - 1);

    // Scan state
    logic [PW-1:0] r_presc;
    logic [IW-1:0] r_idx;
    logic [FW-1:0] r_frame;
    logic          r_blink;

    // Shadow display registers, updated only by load
    logic [4*NUM_DIGITS-1:0] r_digits;
    logic [NUM_DIGITS-1:0]   r_en;
    logic [NUM_DIGITS-1:0]   r_blk;
    logic [NUM_DIGITS-1:0]   r_dpm;
    logic                    r_lz;

    logic       w_slot_tc;
    logic       w_frame_tc;
    logic [3:0] w_cur_dig;
    logic       w_cur_en;
    logic       w_cur_blk;
    logic       w_cur_dpm;
    logic       w_cur_sup;
    logic       w_zero_run;
    logic       w_cur_blank;
    logic [6:0] w_dec_seg;

    assign w_slot_tc  = (r_presc == PRESC_LAST);
    assign w_frame_tc = w_slot_tc && (r_idx == IDX_LAST);

    // Prescaler, digit index, frame counter and blink phase
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_presc <= '0;
            r_idx   <= '0;
            r_frame <= '0;
            r_blink <= 1'b0;
        end else begin
            r_presc <= w_slot_tc ? '0 : r_presc + 1'b1;
            if (w_slot_tc) begin
                r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
            end
            if (w_frame_tc) begin
                if (r_frame == FRAME_LAST) begin
                    r_frame <= '0;
                    r_blink <= ~r_blink;
                end else begin
                    r_frame <= r_frame + 1'b1;
                end
            end
        end
    end

    // Atomic capture of all shadow inputs on the load strobe
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_digits <= '0;
            r_en     <= '0;
            r_blk    <= '0;
            r_dpm    <= '0;
            r_lz     <= 1'b0;
        end else if (load) begin
            r_digits <= digits;
            r_en     <= digit_en;
            r_blk    <= blink_msk;
            r_dpm    <= dp_msk;
            r_lz     <= lz_en;
        end
    end

    // Select the current digit and decide suppression by scanning from the most significant digit down
    always_comb begin
        w_cur_dig  = 4'h0;
        w_cur_en   = 1'b0;
        w_cur_blk  = 1'b0;
        w_cur_dpm  = 1'b0;
        w_cur_sup  = 1'b0;
        w_zero_run = 1'b1;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            w_zero_run = w_zero_run && (r_digits[4*k +: 4] == 4'h0);
            if (r_idx == IW'(k)) begin
                w_cur_dig = r_digits[4*k +: 4];
                w_cur_en  = r_en[k];
                w_cur_blk = r_blk[k];
                w_cur_dpm = r_dpm[k];
                w_cur_sup = r_lz && w_zero_run && (k != 0);
            end
        end
    end

    assign w_cur_blank = !w_cur_en || (w_cur_blk && r_blink) || w_cur_sup;

    hex7seg_decode u_dec (
        .i_hex (w_cur_dig),
        .o_seg (w_dec_seg)
    );

    // Registered slot outputs: ghost-blank window first, then the selected anode
    always_ff @(posedge clk) begin
        if (!rst) begin
            seg <= SEG_BLANK;
            an  <= '1;
            dp  <= 1'b1;
        end else if (r_presc < BLANK_END) begin
            seg <= SEG_BLANK;
            an  <= '1;
            dp  <= 1'b1;
        end else begin
            an <= ~(NUM_DIGITS'(1) << r_idx);
            if (w_cur_blank) begin
                seg <= SEG_BLANK;
                dp  <= 1'b1;
            end else begin
                seg <= w_dec_seg;
                dp  <= ~w_cur_dpm;
            end
        end
    end

    // Status LEDs: top bit marks "out of reset", next is the armed flag
    always_ff @(posedge clk) begin
        if (!rst) begin
            led <= '0;
        end else begin
            led <= {1'b1, set, led_in};
        end
    end

endmodule

// File: tb/tb_seg_display_ctrl.sv
module tb_seg_display_ctrl;

    localparam int ND = 4;
    localparam int RD = 4;
    localparam int BC = 1;
    localparam int BD = 2;
    localparam int LW = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            load;
    logic [4*ND-1:0] digits;
    logic [ND-1:0]   digit_en;
    logic [ND-1:0]   blink_msk;
    logic [ND-1:0]   dp_msk;
    logic            lz_en;
    logic            set;
    logic [LW-3:0]   led_in;
    logic [6:0]      seg;
    logic [ND-1:0]   an;
    logic            dp;
    logic [LW-1:0]   led;

    always #5 clk = ~clk;

    seg_display_ctrl #(
        .NUM_DIGITS  (ND),
        .REFRESH_DIV (RD),
        .BLANK_CYC   (BC),
        .BLINK_DIV   (BD),
        .LED_W       (LW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .digits    (digits),
        .digit_en  (digit_en),
        .blink_msk (blink_msk),
        .dp_msk    (dp_msk),
        .lz_en     (lz_en),
        .set       (set),
        .led_in    (led_in),
        .seg       (seg),
        .an        (an),
        .dp        (dp),
        .led       (led)
    );

    int n_chk = 0;
    int n_err = 0;

    // Independent segment table for the reference model
    logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reference model: display contents plus cycles elapsed since reset
    logic [4*ND-1:0] m_dig;
    logic [ND-1:0]   m_en, m_blk, m_dpm;
    logic            m_lz;
    int              m_cyc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: predict from the pre-edge state, advance the model, compare after the edge
    task automatic tick();
        logic [6:0]    e_seg;
        logic [ND-1:0] e_an;
        logic          e_dp;
        logic [LW-1:0] e_led;
        int p, k, d, ph;
        bit blank;
        e_seg = 7'h7F; e_an = '1; e_dp = 1'b1; e_led = '0;
        if (!rst) begin
            m_dig = '0; m_en = '0; m_blk = '0; m_dpm = '0; m_lz = 1'b0; m_cyc = 0;
        end else begin
            p  = m_cyc % RD;
            k  = (m_cyc / RD) % ND;
            ph = (m_cyc / (RD * ND * BD)) % 2;
            e_led = {1'b1, set, led_in};
            if (p >= BC) begin
                e_an[k] = 1'b0;
                d = (m_dig >> (4 * k)) & 15;
                blank = !m_en[k] || (m_blk[k] && ph == 1) ||
                        (m_lz && k != 0 && (m_dig >> (4 * k)) == 0);
                e_seg = blank ? 7'h7F : hex_tab[d];
                e_dp  = blank ? 1'b1 : !m_dpm[k];
            end
            if (load) begin
                m_dig = digits; m_en = digit_en; m_blk = blink_msk; m_dpm = dp_msk; m_lz = lz_en;
            end
            m_cyc++;
        end
        @(posedge clk);
        #1;
        chk("model_seg", 32'(seg), 32'(e_seg));
        chk("model_an",  32'(an),  32'(e_an));
        chk("model_dp",  32'(dp),  32'(e_dp));
        chk("model_led", 32'(led), 32'(e_led));
    endtask

    typedef struct {
        logic [15:0] dig;
        logic [3:0]  en;
        logic [3:0]  blk;
        logic [3:0]  dpm;
        logic        lz;
        int          k;
        bit          late;
        logic [6:0]  seg;
        logic        dp;
    } vec_t;

    vec_t vecs[16];

    task automatic load_pattern(input logic [15:0] d, input logic [3:0] en, input logic [3:0] blk,
                                input logic [3:0] dpm, input logic lz);
        rst = 1'b0; load = 1'b0;
        tick();
        rst = 1'b1; load = 1'b1;
        digits = d; digit_en = en; blink_msk = blk; dp_msk = dpm; lz_en = lz;
        tick();
        load = 1'b0;
    endtask

    initial begin
        rst = 1'b0; load = 1'b0; digits = '0; digit_en = '0; blink_msk = '0; dp_msk = '0;
        lz_en = 1'b0; set = 1'b0; led_in = '0;
        m_dig = '0; m_en = '0; m_blk = '0; m_dpm = '0; m_lz = 1'b0; m_cyc = 0;

        // Reset held with load asserted: load must be ignored
        load = 1'b1; digits = 16'hFFFF; digit_en = 4'hF; set = 1'b1; led_in = 14'h3FFF;
        repeat (3) tick();
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_an",  32'(an),  32'hF);
        chk("rst_dp",  32'(dp),  32'h1);
        chk("rst_led", 32'(led), 32'h0);
        rst = 1'b1; load = 1'b0;
        tick();
        chk("rel_blank_an", 32'(an), 32'hF);
        tick();
        chk("rel_first_an",  32'(an),  32'hE);
        chk("rel_first_seg", 32'(seg), 32'h7F);

        // Single-slot table
        vecs[0]  = '{16'h12A8, 4'hF, 4'h0, 4'h4, 1'b0, 0, 1'b0, 7'h00, 1'b1};
        vecs[1]  = '{16'h12A8, 4'hF, 4'h0, 4'h4, 1'b0, 1, 1'b0, 7'h08, 1'b1};
        vecs[2]  = '{16'h12A8, 4'hF, 4'h0, 4'h4, 1'b0, 2, 1'b0, 7'h24, 1'b0};
        vecs[3]  = '{16'h12A8, 4'hF, 4'h0, 4'h4, 1'b0, 3, 1'b0, 7'h79, 1'b1};
        vecs[4]  = '{16'h0005, 4'hF, 4'h0, 4'h2, 1'b1, 0, 1'b0, 7'h12, 1'b1};
        vecs[5]  = '{16'h0005, 4'hF, 4'h0, 4'h2, 1'b1, 1, 1'b0, 7'h7F, 1'b1};
        vecs[6]  = '{16'h0000, 4'hF, 4'h0, 4'h0, 1'b1, 0, 1'b0, 7'h40, 1'b1};
        vecs[7]  = '{16'h0000, 4'hF, 4'h0, 4'h0, 1'b1, 3, 1'b0, 7'h7F, 1'b1};
        vecs[8]  = '{16'h0000, 4'hF, 4'h0, 4'h0, 1'b0, 3, 1'b0, 7'h40, 1'b1};
        vecs[9]  = '{16'h0305, 4'hF, 4'h0, 4'h0, 1'b1, 1, 1'b0, 7'h40, 1'b1};
        vecs[10] = '{16'h0305, 4'hF, 4'h0, 4'h0, 1'b1, 3, 1'b0, 7'h7F, 1'b1};
        vecs[11] = '{16'h12A8, 4'hB, 4'h0, 4'h4, 1'b0, 2, 1'b0, 7'h7F, 1'b1};
        vecs[12] = '{16'h12A8, 4'hF, 4'h1, 4'h0, 1'b0, 0, 1'b0, 7'h00, 1'b1};
        vecs[13] = '{16'h12A8, 4'hF, 4'h1, 4'h0, 1'b0, 0, 1'b1, 7'h7F, 1'b1};
        vecs[14] = '{16'h12A8, 4'hF, 4'h1, 4'h0, 1'b0, 1, 1'b1, 7'h08, 1'b1};
        vecs[15] = '{16'h0F00, 4'h7, 4'h0, 4'h8, 1'b1, 2, 1'b0, 7'h0E, 1'b1};

        for (int v = 0; v < 16; v++) begin
            logic [3:0] exp_an;
            exp_an = 4'hF;
            exp_an[vecs[v].k] = 1'b0;
            load_pattern(vecs[v].dig, vecs[v].en, vecs[v].blk, vecs[v].dpm, vecs[v].lz);
            repeat (4 * vecs[v].k + 1 + (vecs[v].late ? 32 : 0)) tick();
            chk($sformatf("vec%0d_seg", v), 32'(seg), 32'(vecs[v].seg));
            chk($sformatf("vec%0d_an",  v), 32'(an),  32'(exp_an));
            chk($sformatf("vec%0d_dp",  v), 32'(dp),  32'(vecs[v].dp));
        end

        // Full blink cycle on digit 0 (model checks every cycle)
        load_pattern(16'h12A8, 4'hF, 4'h1, 4'h4, 1'b0);
        repeat (140) tick();

        // Load atomicity and mid-slot load
        load_pattern(16'h12A8, 4'hF, 4'h0, 4'h0, 1'b0);
        digits = 16'h0000;
        tick();
        chk("frozen_seg", 32'(seg), 32'h00);
        digits = 16'h0005; load = 1'b1;
        tick();
        chk("preload_seg", 32'(seg), 32'h00);
        load = 1'b0;
        tick();
        chk("midslot_seg", 32'(seg), 32'h12);

        // Reset in slot 2: scan restarts from index 0 with cleared registers
        load_pattern(16'h12A8, 4'hF, 4'h0, 4'h0, 1'b0);
        repeat (9) tick();
        chk("slot2_an", 32'(an), 32'hB);
        rst = 1'b0;
        tick();
        chk("mid_rst_seg", 32'(seg), 32'h7F);
        chk("mid_rst_an",  32'(an),  32'hF);
        chk("mid_rst_led", 32'(led), 32'h0);
        rst = 1'b1;
        tick();
        tick();
        chk("restart_an",  32'(an),  32'hE);
        chk("restart_seg", 32'(seg), 32'h7F);

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst  = ($urandom_range(0, 199) != 0);
            load = ($urandom_range(0, 7) == 0);
            for (int n = 0; n < ND; n++)
                digits[4*n +: 4] = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(0, 15));
            digit_en  = ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(0, 15));
            blink_msk = 4'($urandom_range(0, 15));
            dp_msk    = 4'($urandom_range(0, 15));
            lz_en     = 1'($urandom_range(0, 1));
            set       = 1'($urandom_range(0, 1));
            led_in    = 14'($urandom_range(0, 16383));
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
